// File: rtl/cp2_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cp2_slave_if                                               |
// | Description : Coprocessor-2 slot interface between the cpu (master) and  |
// |               the coprocessor responder (slave). Instruction, start      |
// |               strobes and transfer-to data flow master->slave; busy,     |
// |               from-data and exception status flow slave->master.         |
// | Ports       : cp_irenable_0/cp_ir_0    instruction load                  |
// |               cp2_as_0                 arithmetic start                  |
// |               cp2_ts_0/tds_0/tdata_0   transfer-to request/strobe/data   |
// |               cp2_fs_0                 transfer-from request             |
// |               cp2_abusy/tbusy/fbusy_0  busy flags                        |
// |               cp2_fds_0/cp2_fdata_0    from-data strobe/data             |
// |               cp2_excs/exc/exccode_0   completion status                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface cp2_slave_if #(
   parameter int DATA_W = 32,
   parameter int EXC_W  = 2
);
   logic              cp_irenable_0;
   logic [31:0]       cp_ir_0;
   logic              cp2_as_0;
   logic              cp2_ts_0;
   logic              cp2_tds_0;
   logic [DATA_W-1:0] cp2_tdata_0;
   logic              cp2_fs_0;
   logic              cp2_abusy_0;
   logic              cp2_tbusy_0;
   logic              cp2_fbusy_0;
   logic              cp2_fds_0;
   logic [DATA_W-1:0] cp2_fdata_0;
   logic              cp2_excs_0;
   logic              cp2_exc_0;
   logic [EXC_W-1:0]  cp2_exccode_0;

   modport master (
      output cp_irenable_0, cp_ir_0, cp2_as_0, cp2_ts_0, cp2_tds_0,
             cp2_tdata_0, cp2_fs_0,
      input  cp2_abusy_0, cp2_tbusy_0, cp2_fbusy_0, cp2_fds_0, cp2_fdata_0,
             cp2_excs_0, cp2_exc_0, cp2_exccode_0
   );

   modport slave (
      input  cp_irenable_0, cp_ir_0, cp2_as_0, cp2_ts_0, cp2_tds_0,
             cp2_tdata_0, cp2_fs_0,
      output cp2_abusy_0, cp2_tbusy_0, cp2_fbusy_0, cp2_fds_0, cp2_fdata_0,
             cp2_excs_0, cp2_exc_0, cp2_exccode_0
   );
endinterface
`default_nettype wire

// File: rtl/cp2_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cp2_slave                                                  |
// | Description : Coprocessor-2 responder. 8 x DATA_W register file,         |
// |               single-cycle MOV/ADD/SUB, iterative 32-step shift-add MUL. |
// |               Build option: define CP2_MUL_EN to include the multiplier  |
// |               (func 3); without it func 3 reports an illegal function.   |
// | Ports       : clk  system clock                                          |
// |               rst  synchronous active-high reset                         |
// |               cp   cp2_slave_if.slave (instruction, start, transfer-to,  |
// |                    transfer-from, busy and completion status signals)    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module cp2_slave #(
   parameter int DATA_W = 32,
   parameter int EXC_W  = 2
) (
   input  wire logic   clk,
   input  wire logic   rst,
   cp2_slave_if.slave  cp
);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_exec = 2'd1;
`ifdef CP2_MUL_EN
   localparam logic [1:0] c_st_mult = 2'd2;
   localparam int         c_cnt_w   = $clog2(DATA_W);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);
   localparam logic [5:0] c_func_mul = 6'd3;
`endif
   localparam logic [5:0] c_func_mov = 6'd0;
   localparam logic [5:0] c_func_add = 6'd1;
   localparam logic [5:0] c_func_sub = 6'd2;
   localparam logic [EXC_W-1:0] c_code_none    = EXC_W'(0);
   localparam logic [EXC_W-1:0] c_code_illegal = EXC_W'(1);
   localparam logic [EXC_W-1:0] c_code_ovf     = EXC_W'(2);

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [DATA_W-1:0] r_regs [8];
   logic [31:0]       r_ir;
   logic [5:0]        r_func;
   logic [2:0]        r_rd;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_fdata;
   logic              r_fds;
   logic              r_excs;
   logic              r_exc;
   logic [EXC_W-1:0]  r_exccode;
`ifdef CP2_MUL_EN
   logic [c_cnt_w-1:0] r_cnt;
   logic [DATA_W-1:0]  r_acc;
   logic [DATA_W-1:0]  w_acc_next;
`endif

   // ------------------------------------------------------------------
   // Decode of the currently loaded instruction
   // ------------------------------------------------------------------
   logic [5:0]        w_ir_func;
   logic [2:0]        w_ir_rd;
   logic [2:0]        w_ir_rs;
   logic [2:0]        w_ir_rt;
   logic              w_unused_ir;
   logic              w_abusy;
   logic              w_ts_wr;
   logic              w_start;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;

   assign w_ir_func   = r_ir[5:0];
   assign w_ir_rd     = r_ir[10:8];
   assign w_ir_rs     = r_ir[13:11];
   assign w_ir_rt     = r_ir[16:14];
   assign w_unused_ir = ^{r_ir[31:17], r_ir[7:6]};

   assign w_ts_wr = cp.cp2_ts_0 & cp.cp2_tds_0 & ~w_abusy;
   assign w_start = cp.cp2_as_0 & ~w_abusy;

   // A transfer-to landing on the same edge as the start is forwarded
   // into the captured operands so the op sees the freshly written value.
   assign w_op_a = (w_ts_wr && (w_ir_rs == w_ir_rd)) ? cp.cp2_tdata_0 : r_regs[w_ir_rs];
   assign w_op_b = (w_ts_wr && (w_ir_rt == w_ir_rd)) ? cp.cp2_tdata_0 : r_regs[w_ir_rt];

`ifdef CP2_MUL_EN
   // r_a shifts left and r_b shifts right each step, so bit 0 of r_b
   // always selects the correctly weighted partial product.
   assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
`endif

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (cp.cp2_as_0) begin
               w_state_next = c_st_exec;
`ifdef CP2_MUL_EN
               if (w_ir_func == c_func_mul) begin
                  w_state_next = c_st_mult;
               end
`endif
            end
         end
         c_st_exec: w_state_next = c_st_idle;
`ifdef CP2_MUL_EN
         c_st_mult: begin
            if (r_cnt == c_cnt_last) begin
               w_state_next = c_st_idle;
            end
         end
`endif
         default: w_state_next = c_st_idle;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (busy and completion decode)
   // ------------------------------------------------------------------
   logic              w_done;
   logic              w_illegal;
   logic              w_ovf;
   logic [DATA_W-1:0] w_result;
   logic [DATA_W-1:0] w_sum;
   logic [DATA_W-1:0] w_diff;

   assign w_sum  = r_a + r_b;
   assign w_diff = r_a - r_b;

   always_comb begin
      w_abusy   = (r_state != c_st_idle);
      w_done    = 1'b0;
      w_illegal = 1'b0;
      w_ovf     = 1'b0;
      w_result  = '0;
      case (r_state)
         c_st_exec: begin
            w_done = 1'b1;
            case (r_func)
               c_func_mov: w_result = r_a;
               c_func_add: begin
                  w_result = w_sum;
                  w_ovf    = (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                             (w_sum[DATA_W-1] != r_a[DATA_W-1]);
               end
               c_func_sub: begin
                  w_result = w_diff;
                  w_ovf    = (r_a[DATA_W-1] != r_b[DATA_W-1]) &&
                             (w_diff[DATA_W-1] != r_a[DATA_W-1]);
               end
               // func 3 only reaches EXEC when the multiplier is absent.
               default: w_illegal = 1'b1;
            endcase
         end
`ifdef CP2_MUL_EN
         c_st_mult: begin
            w_done   = (r_cnt == c_cnt_last);
            w_result = w_acc_next;
         end
`endif
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= '0;
         end
         r_ir      <= '0;
         r_func    <= '0;
         r_rd      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_fdata   <= '0;
         r_fds     <= 1'b0;
         r_excs    <= 1'b0;
         r_exc     <= 1'b0;
         r_exccode <= c_code_none;
`ifdef CP2_MUL_EN
         r_cnt     <= '0;
         r_acc     <= '0;
`endif
      end else begin
         r_fds  <= 1'b0;
         r_excs <= 1'b0;

         if (cp.cp_irenable_0) begin
            r_ir <= cp.cp_ir_0;
         end

         if (w_ts_wr) begin
            r_regs[w_ir_rd] <= cp.cp2_tdata_0;
         end

         // Reads the pre-edge register value, so a same-edge transfer-to
         // to the same register returns the old contents.
         if (cp.cp2_fs_0 && !w_abusy) begin
            r_fdata <= r_regs[w_ir_rs];
            r_fds   <= 1'b1;
         end

         if (w_start) begin
            r_func <= w_ir_func;
            r_rd   <= w_ir_rd;
            r_a    <= w_op_a;
            r_b    <= w_op_b;
`ifdef CP2_MUL_EN
            r_cnt  <= '0;
            r_acc  <= '0;
`endif
         end

`ifdef CP2_MUL_EN
         if (r_state == c_st_mult) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
         end
`endif

         // Completion only happens while busy, so it never collides with
         // a transfer-to write (those require the slot to be idle).
         if (w_done) begin
            if (!w_illegal && !w_ovf) begin
               r_regs[r_rd] <= w_result;
            end
            r_excs    <= 1'b1;
            r_exc     <= w_illegal | w_ovf;
            r_exccode <= w_illegal ? c_code_illegal :
                         (w_ovf ? c_code_ovf : c_code_none);
         end
      end
   end

   assign cp.cp2_abusy_0   = w_abusy;
   assign cp.cp2_tbusy_0   = w_abusy;
   assign cp.cp2_fbusy_0   = w_abusy;
   assign cp.cp2_fds_0     = r_fds;
   assign cp.cp2_fdata_0   = r_fdata;
   assign cp.cp2_excs_0    = r_excs;
   assign cp.cp2_exc_0     = r_exc;
   assign cp.cp2_exccode_0 = r_exccode;

endmodule
`default_nettype wire

// File: tb/tb_cp2_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cp2_slave                                               |
// | Description : Self-checking bench for cp2_slave. Stimulus tasks push     |
// |               expected completion status and from-data into queues; a    |
// |               negedge monitor pops and compares whenever the DUT strobes.|
// |               Reference model: plain register array plus wide signed /   |
// |               unsigned arithmetic. Honours CP2_MUL_EN like the design.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_cp2_slave;
   localparam int DATA_W = 32;
   localparam int EXC_W  = 2;

   typedef struct {
      int       cyc;
      bit       exc;
      bit [1:0] code;
   } exc_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   exc_t        exc_q[$];
   logic [31:0] fd_q[$];
   logic [31:0] model [8];
   exc_t        mon_e;
   logic [31:0] mon_d;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cp2_slave_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) bus ();

   cp2_slave #(.DATA_W(DATA_W), .EXC_W(EXC_W)) dut (
      .clk (clk),
      .rst (rst),
      .cp  (bus.slave)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: compare every strobe against the head of its queue.
   always @(negedge clk) begin
      if (bus.cp2_excs_0 === 1'b1) begin
         if (exc_q.size() == 0) begin
            check("unexpected_excs", 1, 0);
         end else begin
            mon_e = exc_q.pop_front();
            check("excs_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("exc", 64'(bus.cp2_exc_0), 64'(mon_e.exc));
            check("exccode", 64'(bus.cp2_exccode_0), 64'(mon_e.code));
         end
      end
      if (bus.cp2_fds_0 === 1'b1) begin
         if (fd_q.size() == 0) begin
            check("unexpected_fds", 1, 0);
         end else begin
            mon_d = fd_q.pop_front();
            check("fdata", 64'(bus.cp2_fdata_0), 64'(mon_d));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 5))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   // Reference semantics of one arithmetic op.
   function automatic void model_op(input bit [5:0] f, input bit [31:0] a, input bit [31:0] b,
                                    output bit wr, output bit [31:0] res,
                                    output bit exc, output bit [1:0] code);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint s;
      bit [63:0] p;
      wr = 1'b1; exc = 1'b0; code = 2'd0; res = 32'd0; s = 0; p = 64'd0;
      case (f)
         6'd0: res = a;
         6'd1: s = sa + sb;
         6'd2: s = sa - sb;
`ifdef CP2_MUL_EN
         6'd3: begin
            p   = {32'd0, a} * {32'd0, b};
            res = p[31:0];
         end
`endif
         default: begin wr = 1'b0; exc = 1'b1; code = 2'd1; end
      endcase
      if (f == 6'd1 || f == 6'd2) begin
         res = s[31:0];
         if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
            wr = 1'b0; exc = 1'b1; code = 2'd2;
         end
      end
   endfunction

   task automatic drive_ir(input bit [5:0] f, input bit [2:0] rd, input bit [2:0] rs, input bit [2:0] rt);
      bus.cp_irenable_0 = 1'b1;
      bus.cp_ir_0       = {15'($urandom), rt, rs, rd, 2'($urandom), f};
      tick();
      bus.cp_irenable_0 = 1'b0;
   endtask

   task automatic write_reg(input bit [2:0] rd, input logic [31:0] d);
      drive_ir(6'd0, rd, 3'd0, 3'd0);
      bus.cp2_ts_0 = 1'b1; bus.cp2_tds_0 = 1'b1; bus.cp2_tdata_0 = d;
      tick();
      bus.cp2_ts_0 = 1'b0; bus.cp2_tds_0 = 1'b0;
      model[rd] = d;
   endtask

   task automatic read_reg(input bit [2:0] rs);
      drive_ir(6'd0, 3'd0, rs, 3'd0);
      bus.cp2_fs_0 = 1'b1;
      fd_q.push_back(model[rs]);
      tick();
      bus.cp2_fs_0 = 1'b0;
   endtask

   // Transfer-to and transfer-from on the same edge, same register.
   task automatic same_edge_rw(input bit [2:0] r, input logic [31:0] d);
      drive_ir(6'd0, r, r, 3'd0);
      bus.cp2_ts_0 = 1'b1; bus.cp2_tds_0 = 1'b1; bus.cp2_tdata_0 = d;
      bus.cp2_fs_0 = 1'b1;
      fd_q.push_back(model[r]);
      tick();
      bus.cp2_ts_0 = 1'b0; bus.cp2_tds_0 = 1'b0; bus.cp2_fs_0 = 1'b0;
      model[r] = d;
      tick();
   endtask

   task automatic do_op(input bit [5:0] f, input bit [2:0] rd, input bit [2:0] rs, input bit [2:0] rt,
                        input bit poke, input bit fwd, input logic [31:0] fwd_data, input bit rst_mid);
      bit [31:0] a, b, res;
      bit        wr, exc, is_mul;
      bit [1:0]  code;
      int        k, n;
      exc_t      e;
      drive_ir(f, rd, rs, rt);
      if (fwd) begin
         bus.cp2_ts_0 = 1'b1; bus.cp2_tds_0 = 1'b1; bus.cp2_tdata_0 = fwd_data;
         model[rd] = fwd_data;
      end
      a = model[rs];
      b = model[rt];
      model_op(f, a, b, wr, res, exc, code);
      is_mul = 1'b0;
`ifdef CP2_MUL_EN
      is_mul = (f == 6'd3);
`endif
      k = cyc;
      if (!rst_mid) begin
         e.cyc = k + (is_mul ? 33 : 2); e.exc = exc; e.code = code;
         exc_q.push_back(e);
      end
      bus.cp2_as_0 = 1'b1;
      tick();
      bus.cp2_as_0 = 1'b0; bus.cp2_ts_0 = 1'b0; bus.cp2_tds_0 = 1'b0;
      check("busy_after_as", 64'({bus.cp2_abusy_0, bus.cp2_tbusy_0, bus.cp2_fbusy_0}), 64'(3'b111));
      if (rst_mid) begin
         if (is_mul) repeat (9) tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         check("abusy_after_rst", 64'(bus.cp2_abusy_0), 0);
         for (int i = 0; i < 8; i++) model[i] = 32'd0;
         for (int i = 0; i < 8; i++) read_reg(3'(i));
         return;
      end
      if (poke) begin
         // Start, transfer-to and an IR reload while busy: all must be inert
         // for the running op.
         bus.cp2_as_0 = 1'b1; bus.cp2_ts_0 = 1'b1; bus.cp2_tds_0 = 1'b1;
         bus.cp2_tdata_0 = $urandom;
         bus.cp_irenable_0 = 1'b1; bus.cp_ir_0 = $urandom;
         tick();
         bus.cp2_as_0 = 1'b0; bus.cp2_ts_0 = 1'b0; bus.cp2_tds_0 = 1'b0;
         bus.cp_irenable_0 = 1'b0;
      end
      n = 0;
      while (bus.cp2_abusy_0 && n < 40) begin
         tick();
         n++;
      end
      check("busy_cycles", 64'(n + int'(poke)), 64'(is_mul ? 32 : 1));
      if (wr) model[rd] = res;
      tick();
   endtask

   initial begin
      bus.cp_irenable_0 = 1'b0; bus.cp_ir_0 = 32'd0; bus.cp2_as_0 = 1'b0;
      bus.cp2_ts_0 = 1'b0; bus.cp2_tds_0 = 1'b0; bus.cp2_tdata_0 = 32'd0;
      bus.cp2_fs_0 = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 32'd0;

      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      check("rst_abusy",   64'(bus.cp2_abusy_0), 0);
      check("rst_tbusy",   64'(bus.cp2_tbusy_0), 0);
      check("rst_fbusy",   64'(bus.cp2_fbusy_0), 0);
      check("rst_fds",     64'(bus.cp2_fds_0), 0);
      check("rst_excs",    64'(bus.cp2_excs_0), 0);
      check("rst_exc",     64'(bus.cp2_exc_0), 0);
      check("rst_exccode", 64'(bus.cp2_exccode_0), 0);
      check("rst_fdata",   64'(bus.cp2_fdata_0), 0);

      // Transfer-to then transfer-from
      write_reg(3'd2, 32'h0000_1234);
      read_reg(3'd2);

      // ADD 5 + 7
      write_reg(3'd1, 32'd5);
      write_reg(3'd2, 32'd7);
      do_op(6'd1, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 32'd0, 1'b0);
      read_reg(3'd3);

      // Signed overflow: no write to r4
      write_reg(3'd1, 32'h7FFF_FFFF);
      write_reg(3'd2, 32'd1);
      do_op(6'd1, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 32'd0, 1'b0);
      read_reg(3'd4);
      do_op(6'd2, 3'd4, 3'd2, 3'd1, 1'b0, 1'b0, 32'd0, 1'b0);
      read_reg(3'd4);

      // MUL (illegal when multiplier absent), with busy-time pokes
      write_reg(3'd1, 32'h0001_0003);
      write_reg(3'd2, 32'h0000_0010);
      do_op(6'd3, 3'd5, 3'd1, 3'd2, 1'b1, 1'b0, 32'd0, 1'b0);
      read_reg(3'd5);

      // Illegal function
      do_op(6'h3F, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 32'd0, 1'b0);
      read_reg(3'd6);

      // Same-edge read/write returns old value
      same_edge_rw(3'd2, 32'h0000_ABCD);
      read_reg(3'd2);

      // Start together with transfer-to: operand forwarding
      do_op(6'd1, 3'd1, 3'd1, 3'd2, 1'b0, 1'b1, 32'd100, 1'b0);
      read_reg(3'd1);

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         int       sel;
         bit [5:0] f;
         sel = $urandom_range(0, 3);
         case (sel)
            0: write_reg(3'($urandom_range(0, 7)), rand_data());
            1: read_reg(3'($urandom_range(0, 7)));
            default: begin
               case ($urandom_range(0, 4))
                  0: f = 6'd0;
                  1: f = 6'd1;
                  2: f = 6'd2;
                  3: f = 6'd3;
                  default: f = 6'($urandom_range(4, 63));
               endcase
               do_op(f, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), rand_data(), 1'b0);
            end
         endcase
      end
      for (int i = 0; i < 8; i++) read_reg(3'(i));

      // Reset in the middle of an operation
      write_reg(3'd1, 32'h1234_5678);
      write_reg(3'd2, 32'h0000_0003);
      do_op(6'd3, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0, 32'd0, 1'b1);
      write_reg(3'd0, 32'hCAFE_F00D);
      read_reg(3'd0);

      repeat (4) tick();
      check("exc_queue_drained", 64'(exc_q.size()), 0);
      check("fd_queue_drained", 64'(fd_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/cp2_slave.md
Name: cp2_slave

Overview:
- Coprocessor-2 responder: the coprocessor end of the cpu's cp2 interface. It consumes the instruction, start strobes and transfer data the cpu drives, and produces the busy, from-data and exception signals the cpu samples.
- Holds 8 x 32-bit coprocessor registers.
- Executes MOV/ADD/SUB in a single cycle; executes MUL iteratively.
- Sits beside cpu on the same clk, one instance per coprocessor slot (suffix _0).

Parameters:
- DATA_W, 32, word width; must match the cpu word data bus.
- EXC_W, 2, width of cp2_exccode_0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cp_irenable_0  in  1  latch cp_ir_0 into IR this edge
- cp_ir_0  in  32  instruction word; func=[5:0], rd=[10:8], rs=[13:11], rt=[16:14]
- cp2_as_0  in  1  arithmetic start strobe (1 cycle)
- cp2_ts_0  in  1  transfer-to request
- cp2_tds_0  in  1  transfer-to data strobe
- cp2_tdata_0  in  DATA_W  transfer-to data
- cp2_fs_0  in  1  transfer-from request
- cp2_abusy_0  out  1  arithmetic busy
- cp2_tbusy_0  out  1  transfer-to blocked
- cp2_fbusy_0  out  1  transfer-from blocked
- cp2_fds_0  out  1  from-data valid pulse
- cp2_fdata_0  out  DATA_W  from-data
- cp2_excs_0  out  1  completion/exception status strobe
- cp2_exc_0  out  1  exception flag, qualified by excs
- cp2_exccode_0  out  EXC_W  0=none, 1=illegal func, 2=signed overflow

Behaviour:
- Clock/reset: single clock clk. Reset is synchronous and active-high on rst.
- Reset values: all regs, IR, operands, counter, fdata = 0; state IDLE; abusy, tbusy, fbusy, fds, excs, exc = 0; exccode = 0.
- Reset mid-operation: the operation is abandoned, no excs is produced, registers are cleared.
- IR: loaded on any edge with cp_irenable_0=1, including while busy.
- AS capture: on an AS edge in IDLE, func, rd, A=reg[rs] and B=reg[rt] are captured. A later IR load does not affect the running op.
- Funcs:
  - 0 MOV: rd<=A
  - 1 ADD: rd<=A+B
  - 2 SUB: rd<=A-B
  - 3 MUL: rd<=low 32 bits of A*B, unsigned
  - other values: illegal
- FSM states: IDLE, EXEC, MULT.
  - IDLE + as: func 3 -> MULT with count=0; all other funcs (including illegal) -> EXEC.
  - EXEC (1 cycle) -> IDLE.
  - MULT: shift-add one bit of B per cycle, count 0..31; at count==31 -> IDLE.
- Completion edge (end of EXEC, or end of MULT count 31):
  - Write rd, except for illegal func or overflow (no write).
  - Register excs=1 for exactly one cycle with exc/exccode.
  - Overflow is signed: ADD when operand signs are equal and the result sign differs; SUB when operand signs differ and the result sign differs from A.
- Latency: AS in cycle 0.
  - ADD/SUB/MOV: EXEC in cycle 1, excs in cycle 2.
  - MUL: MULT in cycles 1..32, excs in cycle 33.
- Busy signals: abusy = (state!=IDLE). tbusy = abusy. fbusy = abusy.
- AS while abusy: ignored; no queueing, no exception.
- Transfer-to: ts & tds & !tbusy -> reg[IR.rd] <= tdata at that edge. ts & tds while tbusy: data dropped; the cpu must hold the strobes until tbusy falls.
- Transfer-from: fs & !fbusy -> fdata <= reg[IR.rs], fds=1 in the next cycle only. fdata holds its value otherwise.
- fs on the same edge as a ts write to the same register returns the old value.
- AS and TS together in IDLE: the TS write occurs, and operand capture forwards tdata when rs or rt equals IR.rd.
- Completion write and excs in the same cycle as a new AS: the new AS is ignored, because abusy is still high during the completion cycle.

Optional Feature:
- Macro: CP2_MUL_EN.
- Defined: MULT state and 32-cycle shift-add datapath present; func 3 behaves as described.
- Undefined: no multiplier logic and no MULT state. Func 3 is treated as illegal: EXEC, excs with exc=1, exccode=1, no write.

Test Plan:
- Reset then transfer-to:
  - rst 1 cycle -> all outputs 0.
  - IR rd=2, ts+tds tdata=0x0000_1234 -> fs with IR rs=2 gives fds pulse one cycle later, fdata=0x0000_1234.
- ADD:
  - r1=5, r2=7, IR ADD rd=3 rs=1 rt=2, as at cycle 0 -> abusy high cycle 1, excs=1 exc=0 at cycle 2.
  - fs rs=3 -> fdata=12.
- Overflow:
  - r1=0x7FFF_FFFF, r2=1, ADD rd=4 -> excs with exc=1 exccode=2; r4 unchanged (0).
- MUL (CP2_MUL_EN defined):
  - r1=0x0001_0003, r2=0x0000_0010, MUL rd=5 -> abusy cycles 1..32, excs cycle 33, r5=0x0010_0030.
  - as and ts asserted during busy -> both ignored.
- Illegal func:
  - func=0x3F -> excs exc=1 exccode=1, no register written.
  - Without CP2_MUL_EN, func=3 gives the same result.
- Reset mid-MUL:
  - rst at cycle 10 of MULT -> abusy=0 the next cycle, no excs, all registers 0.
